// File: rtl/mm_bus_ctrl.sv
// mm_bus_ctrl: memory-mapped I/O controller between the CPU MM port and
// NUM_CH peripherals. It decodes the MM address window and drives a one-hot
// strobe to the addressed channel. The CPU is stalled until that channel
// acks or the access times out. Read data is returned with a one-cycle valid
// pulse, and errors produce a one-cycle bus_err pulse.
module mm_bus_ctrl #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                NUM_CH   = 4,
  parameter int                CH_LSB   = 4,
  parameter logic [2:0]        MM_TAG   = 3'b111,
  parameter int                TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(16'hDEAD)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_rvalid,
  output logic                     cpu_stall,
  output logic                     bus_err,
  output logic [7:0]               err_cnt,
  output logic [ADDR_W-1:0]        ch_addr,
  output logic [DATA_W-1:0]        ch_wdata,
  output logic [NUM_CH-1:0]        ch_re,
  output logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  input  logic [NUM_CH-1:0]        ch_ack
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  logic [CH_W-1:0]   sel;
  logic              op_wr;
  logic [7:0]        cnt;

  logic [CH_W-1:0]   req_ch;
  logic              mm_req;
  logic              req_valid;
  logic [NUM_CH-1:0] req_onehot;
  logic [DATA_W-1:0] sel_rdata;
  logic              sel_ack;

  assign req_ch = cpu_addr[CH_LSB +: CH_W];
  assign mm_req = (cpu_re | cpu_we) && (cpu_addr[ADDR_W-1 -: 3] == MM_TAG);

  // Channel decode of the incoming request and mux of the latched channel's return path
  always_comb begin
    req_valid  = (int'(req_ch) < NUM_CH);
    req_onehot = '0;
    sel_rdata  = '0;
    sel_ack    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      req_onehot[k] = (int'(req_ch) == k);
      if (int'(sel) == k) begin
        sel_rdata = ch_rdata[k*DATA_W +: DATA_W];
        sel_ack   = ch_ack[k];
      end
    end
  end

  // Stall is combinational so the CPU freezes in the same cycle it issues the request
  assign cpu_stall = rst_n && (((state == IDLE) && mm_req) || (state == ACCESS));

  // Access FSM with registered strobes, read return, error pulse and saturating error count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      op_wr      <= 1'b0;
      cnt        <= '0;
      ch_re      <= '0;
      ch_we      <= '0;
      ch_addr    <= '0;
      ch_wdata   <= '0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      bus_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      cpu_rvalid <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (mm_req) begin
            if (req_valid) begin
              ch_addr  <= cpu_addr;
              ch_wdata <= cpu_wdata;
              sel      <= req_ch;
              op_wr    <= cpu_we;
              cnt      <= 8'd1;
              if (cpu_we) ch_we <= req_onehot;
              else        ch_re <= req_onehot;
              state    <= ACCESS;
            end else begin
              // Bad channel: no strobe at all, straight to an error completion
              if (!cpu_we) begin
                cpu_rvalid <= 1'b1;
                cpu_rdata  <= ERR_DATA;
              end
              bus_err <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
              state   <= DONE;
            end
          end
        end
        ACCESS: begin
          if (sel_ack) begin
            // Ack has priority over a timeout reached in the same cycle
            ch_re <= '0;
            ch_we <= '0;
            if (!op_wr) begin
              cpu_rvalid <= 1'b1;
              cpu_rdata  <= sel_rdata;
            end
            state <= DONE;
          end else if (cnt >= 8'(TIMEOUT)) begin
            ch_re <= '0;
            ch_we <= '0;
            if (!op_wr) begin
              cpu_rvalid <= 1'b1;
              cpu_rdata  <= ERR_DATA;
            end
            bus_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          // The request still visible here belongs to the completed access
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_bus_ctrl.sv
// tb_mm_bus_ctrl: randomized and directed checks of mm_bus_ctrl against a
// transaction-level model. A 4-channel instance is the main target. A
// 3-channel instance with a short timeout covers the bad-channel case and
// the case where the ack and the timeout land in the same cycle.
module tb_mm_bus_ctrl;

  localparam int TIMEOUT = 15;
  localparam logic [15:0] ERR_DATA = 16'hDEAD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_re = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_wdata = '0;

  logic [15:0] cpu_rdata;
  logic        cpu_rvalid, cpu_stall, bus_err;
  logic [7:0]  err_cnt;
  logic [15:0] ch_addr, ch_wdata;
  logic [3:0]  ch_re, ch_we;
  logic [63:0] ch_rdata = '0;
  logic [3:0]  ch_ack = '0;

  logic [15:0] cpu_rdata3;
  logic        cpu_rvalid3, cpu_stall3, bus_err3;
  logic [7:0]  err_cnt3;
  logic [15:0] ch_addr3, ch_wdata3;
  logic [2:0]  ch_re3, ch_we3;
  logic [47:0] ch_rdata3 = '0;
  logic [2:0]  ch_ack3 = '0;

  int          n_pass = 0;
  int          n_checks = 0;
  logic [15:0] m_rdata = '0;
  int          m_err_cnt = 0;

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  mm_bus_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .cpu_stall(cpu_stall), .bus_err(bus_err), .err_cnt(err_cnt), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_re(ch_re), .ch_we(ch_we), .ch_rdata(ch_rdata), .ch_ack(ch_ack)
  );

  mm_bus_ctrl #(.NUM_CH(3), .TIMEOUT(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata3), .cpu_rvalid(cpu_rvalid3),
    .cpu_stall(cpu_stall3), .bus_err(bus_err3), .err_cnt(err_cnt3), .ch_addr(ch_addr3),
    .ch_wdata(ch_wdata3), .ch_re(ch_re3), .ch_we(ch_we3), .ch_rdata(ch_rdata3), .ch_ack(ch_ack3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete CPU access on the 4-channel instance. ack_at is the ACCESS cycle
  // (1-based) in which channel ack_ch acks; 0 or > TIMEOUT means no ack.
  task automatic applyStimulus(input logic [15:0] addr, input logic re, input logic we,
                               input logic [15:0] wdata, input int ack_at, input int ack_ch,
                               input logic [15:0] rdata_val);
    logic       mm;
    logic       is_rd;
    logic       err;
    int         ch;
    int         n_acc;
    logic [3:0] exp_oh;
    mm     = (re | we) && (addr[15:13] == 3'b111);
    ch     = int'(addr[5:4]);
    is_rd  = re && !we;
    exp_oh = 4'b0001 << ch;
    if (ack_ch == ch && ack_at >= 1 && ack_at <= TIMEOUT) begin
      n_acc = ack_at;
      err   = 1'b0;
    end else begin
      n_acc = TIMEOUT;
      err   = 1'b1;
    end
    cpu_addr  = addr;
    cpu_re    = re;
    cpu_we    = we;
    cpu_wdata = wdata;
    ch_ack    = '0;
    ch_rdata  = {$urandom, $urandom};
    ch_rdata[ch*16 +: 16] = rdata_val;
    #1;
    checkOutput("stall_req", 32'(cpu_stall), 32'(mm));
    if (!mm) begin
      tick();
      checkOutput("nonmm_re", 32'(ch_re), 32'd0);
      checkOutput("nonmm_we", 32'(ch_we), 32'd0);
      checkOutput("nonmm_stall", 32'(cpu_stall), 32'd0);
      checkOutput("nonmm_rvalid", 32'(cpu_rvalid), 32'd0);
      cpu_re = 1'b0;
      cpu_we = 1'b0;
      return;
    end
    tick();
    for (int n = 1; n <= n_acc; n++) begin
      ch_ack = (n == ack_at) ? (4'b0001 << ack_ch) : 4'b0000;
      #1;
      checkOutput("acc_re", 32'(ch_re), is_rd ? 32'(exp_oh) : 32'd0);
      checkOutput("acc_we", 32'(ch_we), is_rd ? 32'd0 : 32'(exp_oh));
      checkOutput("acc_stall", 32'(cpu_stall), 32'd1);
      if (n == 1) begin
        checkOutput("ch_addr", 32'(ch_addr), 32'(addr));
        checkOutput("ch_wdata", 32'(ch_wdata), 32'(wdata));
      end
      tick();
    end
    ch_ack = '0;
    #1;
    if (is_rd) m_rdata = err ? ERR_DATA : rdata_val;
    if (err && m_err_cnt < 255) m_err_cnt++;
    checkOutput("done_stall", 32'(cpu_stall), 32'd0);
    checkOutput("done_re", 32'(ch_re), 32'd0);
    checkOutput("done_we", 32'(ch_we), 32'd0);
    checkOutput("done_rvalid", 32'(cpu_rvalid), 32'(is_rd));
    checkOutput("done_bus_err", 32'(bus_err), 32'(err));
    checkOutput("done_rdata", 32'(cpu_rdata), 32'(m_rdata));
    checkOutput("done_err_cnt", 32'(err_cnt), 32'(m_err_cnt));
    tick();
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    #1;
    checkOutput("post_rvalid", 32'(cpu_rvalid), 32'd0);
    checkOutput("post_bus_err", 32'(bus_err), 32'd0);
    checkOutput("post_stall", 32'(cpu_stall), 32'd0);
  endtask

  // Directed and randomized sequence
  initial begin
    logic [15:0] addr;
    logic [2:0]  tag;
    int          ack_at;
    int          ack_ch;

    // Reset, with an MM request present to show the stall is masked
    rst_n    = 1'b0;
    cpu_addr = 16'hE020;
    cpu_re   = 1'b1;
    tick(); tick(); tick();
    checkOutput("rst_stall", 32'(cpu_stall), 32'd0);
    checkOutput("rst_re", 32'(ch_re), 32'd0);
    checkOutput("rst_we", 32'(ch_we), 32'd0);
    checkOutput("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    checkOutput("rst_bus_err", 32'(bus_err), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("rst_rdata", 32'(cpu_rdata), 32'd0);
    checkOutput("rst_ch_addr", 32'(ch_addr), 32'd0);
    checkOutput("rst_ch_wdata", 32'(ch_wdata), 32'd0);
    cpu_re = 1'b0;
    rst_n  = 1'b1;
    tick();

    $display("[TB] directed accesses");
    applyStimulus(16'hE020, 1'b1, 1'b0, 16'h0000, 1, 2, 16'h1234);
    checkOutput("read_ch2_data", 32'(cpu_rdata), 32'h1234);
    applyStimulus(16'hE010, 1'b0, 1'b1, 16'hBEEF, 3, 1, 16'h0000);
    checkOutput("write_keeps_rdata", 32'(cpu_rdata), 32'h1234);
    applyStimulus(16'hE030, 1'b1, 1'b0, 16'h0000, 0, 3, 16'h0000);
    checkOutput("timeout_err_cnt1", 32'(err_cnt), 32'd1);
    checkOutput("timeout_rdata", 32'(cpu_rdata), 32'hDEAD);
    for (int i = 0; i < 299; i++)
      applyStimulus(16'hE030, 1'b1, 1'b0, 16'h0000, 0, 3, 16'h0000);
    checkOutput("err_cnt_sat", 32'(err_cnt), 32'd255);

    applyStimulus(16'h2000, 1'b1, 1'b0, 16'h0000, 1, 0, 16'h5555);
    applyStimulus(16'hE020, 1'b1, 1'b1, 16'hA5A5, 2, 2, 16'h7777);
    applyStimulus(16'hE020, 1'b1, 1'b0, 16'h0000, 2, 0, 16'h1111);
    applyStimulus(16'hE000, 1'b1, 1'b0, 16'h0000, TIMEOUT, 0, 16'hCAFE);
    checkOutput("ack_at_timeout", 32'(cpu_rdata), 32'hCAFE);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 40; i++) begin
      tag    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 6)) : 3'b111;
      addr   = {tag, 13'($urandom)};
      ack_at = $urandom_range(0, TIMEOUT + 2);
      ack_ch = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : int'(addr[5:4]);
      applyStimulus(addr, 1'($urandom), 1'($urandom), 16'($urandom), ack_at, ack_ch, 16'($urandom));
    end

    $display("[TB] reset during access");
    cpu_addr = 16'hE020;
    cpu_re   = 1'b1;
    cpu_we   = 1'b0;
    ch_ack   = '0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_re", 32'(ch_re), 32'd0);
    checkOutput("midrst_stall", 32'(cpu_stall), 32'd0);
    checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("midrst_rdata", 32'(cpu_rdata), 32'd0);
    rst_n     = 1'b1;
    cpu_re    = 1'b0;
    m_err_cnt = 0;
    m_rdata   = '0;
    tick();
    applyStimulus(16'hE020, 1'b1, 1'b0, 16'h0000, 1, 2, 16'h4321);

    $display("[TB] three-channel instance");
    rst_n = 1'b0;
    tick(); tick();
    rst_n    = 1'b1;
    tick();
    cpu_addr = 16'hE030;
    cpu_re   = 1'b1;
    cpu_we   = 1'b0;
    ch_ack3  = '0;
    #1;
    checkOutput("badch_stall", 32'(cpu_stall3), 32'd1);
    tick();
    checkOutput("badch_re", 32'(ch_re3), 32'd0);
    checkOutput("badch_bus_err", 32'(bus_err3), 32'd1);
    checkOutput("badch_rvalid", 32'(cpu_rvalid3), 32'd1);
    checkOutput("badch_rdata", 32'(cpu_rdata3), 32'hDEAD);
    checkOutput("badch_err_cnt", 32'(err_cnt3), 32'd1);
    checkOutput("badch_done_stall", 32'(cpu_stall3), 32'd0);
    tick();
    cpu_re = 1'b0;
    #1;
    checkOutput("badch_pulse_end", 32'(bus_err3), 32'd0);
    for (int i = 0; i < 20; i++) tick();

    ch_rdata3 = {16'h0000, 16'h5A5A, 16'h0000};
    cpu_addr  = 16'hE010;
    cpu_re    = 1'b1;
    #1;
    tick();
    for (int n = 1; n <= 4; n++) begin
      ch_ack3 = (n == 4) ? 3'b010 : 3'b000;
      #1;
      checkOutput("tie_re", 32'(ch_re3), 32'h2);
      tick();
    end
    ch_ack3 = '0;
    #1;
    checkOutput("tie_rvalid", 32'(cpu_rvalid3), 32'd1);
    checkOutput("tie_rdata", 32'(cpu_rdata3), 32'h5A5A);
    checkOutput("tie_bus_err", 32'(bus_err3), 32'd0);
    checkOutput("tie_err_cnt", 32'(err_cnt3), 32'd1);
    tick();
    cpu_re = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
